// File: rtl/imm_encode.sv
// imm_encode: packs a signed immediate into RISC-V I/S/SB/U/UJ bit positions
// over a base instruction word and flags immediates that cannot be represented.
// Two-stage valid/ready pipeline; stage 2 drives the outputs.
// Optional feature macro: IMM_ENCODE_ERR_CNT_EN adds a saturating count of
// erroneous output handshakes (err_cnt) with a synchronous clear (err_cnt_clr).
module imm_encode #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      sel_type,
  input  logic [ILEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] instr,
  output logic            imm_err
`ifdef IMM_ENCODE_ERR_CNT_EN
  ,
  input  logic            err_cnt_clr,
  output logic [15:0]     err_cnt
`endif
);

  localparam logic [2:0] TYPE_I  = 3'd1;
  localparam logic [2:0] TYPE_S  = 3'd2;
  localparam logic [2:0] TYPE_SB = 3'd3;
  localparam logic [2:0] TYPE_U  = 3'd4;
  localparam logic [2:0] TYPE_UJ = 3'd5;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic            err;
  } enc_t;

  enc_t enc_c;
  enc_t s1_q;
  logic s1_valid;
  logic s2_load;
  logic accept;

  // Upper bits must be a pure sign extension for the value to fit the field.
  logic fits_12_c;
  logic fits_13_c;
  logic fits_21_c;
  logic fits_32_c;

  assign fits_12_c = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
  assign fits_13_c = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);
  assign fits_21_c = (&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20]);
  assign fits_32_c = (&imm[XLEN-1:31]) | ~(|imm[XLEN-1:31]);

  // Merge the immediate into the base word and compute the range error.
  always_comb begin
    enc_c.instr = base;
    enc_c.err   = 1'b0;
    case (sel_type)
      TYPE_I: begin
        enc_c.instr[31:20] = imm[11:0];
        enc_c.err          = ~fits_12_c;
      end
      TYPE_S: begin
        enc_c.instr[31:25] = imm[11:5];
        enc_c.instr[11:7]  = imm[4:0];
        enc_c.err          = ~fits_12_c;
      end
      TYPE_SB: begin
        enc_c.instr[31]    = imm[12];
        enc_c.instr[7]     = imm[11];
        enc_c.instr[30:25] = imm[10:5];
        enc_c.instr[11:8]  = imm[4:1];
        enc_c.err          = ~fits_13_c | imm[0];
      end
      TYPE_U: begin
        enc_c.instr[31:12] = imm[31:12];
        enc_c.err          = ~fits_32_c | (|imm[11:0]);
      end
      TYPE_UJ: begin
        enc_c.instr[31]    = imm[20];
        enc_c.instr[19:12] = imm[19:12];
        enc_c.instr[20]    = imm[11];
        enc_c.instr[30:21] = imm[10:1];
        enc_c.err          = ~fits_21_c | imm[0];
      end
      default: begin
        enc_c.instr = base;
        enc_c.err   = 1'b0;
      end
    endcase
  end

  // Handshake control: stage 2 can take data when empty or being drained.
  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready;

  // Stage 1: capture on accept, empty once its content moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= enc_c;
    end else if (s1_valid && s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= '0;
      imm_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr   <= s1_q.instr;
        imm_err <= s1_q.err;
      end
    end
  end

`ifdef IMM_ENCODE_ERR_CNT_EN
  // Saturating count of erroneous results handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (err_cnt_clr) begin
      err_cnt <= 16'd0;
    end else if (out_valid && out_ready && imm_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
